mcdt_multi: RTL and testbench

MCDT_MULTI -- requirements
Module: mcdt_multi

---
 rtl/mcdt_pkg.sv | 24 ++
 rtl/chnl_fifo.sv | 64 ++++++
 rtl/mcdt_multi.sv | 114 +++++++++++
 tb/tb_mcdt_multi.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcdt_pkg.sv
// Shared arbitration mode type, default parameters and width helpers
// for the multi-channel data transfer block.
package mcdt_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 32;
  localparam int DEF_ARB_MODE   = int'(ARB_FIXED);

  // Width of a count/margin field: must hold the value FIFO_DEPTH itself.
  function automatic int calc_mw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int calc_idw(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/chnl_fifo.sv
// Per-channel FIFO: power-of-two depth, wrapping pointers, explicit count so
// that full/empty/margin come straight from a register.
module chnl_fifo
  import mcdt_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           push,
  input  logic                           pop,
  input  logic [DATA_W-1:0]              din,
  output logic [DATA_W-1:0]              dout,
  output logic [calc_mw(FIFO_DEPTH)-1:0] count,
  output logic [calc_mw(FIFO_DEPTH)-1:0] margin
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int MW = calc_mw(FIFO_DEPTH);
  localparam logic [MW-1:0] FULL = MW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [MW-1:0]     count_reg;
  logic [MW-1:0]     count_next;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && (count_reg != FULL);
  assign pop_ok  = pop && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push_ok) mem[wr_ptr_reg] <= din;
  end

  // Head word is visible immediately so the output register can load it on the pop edge.
  assign dout   = mem[rd_ptr_reg];
  assign count  = count_reg;
  assign margin = FULL - count_reg;

endmodule

// File: rtl/mcdt_multi.sv
// Multi-channel data transfer: NUM_CH write FIFOs merged by a fixed-priority
// or round-robin arbiter into a single registered output with backpressure.
module mcdt_multi
  import mcdt_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ARB_MODE   = DEF_ARB_MODE
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic [NUM_CH*DATA_W-1:0]              ch_data_i,
  input  logic [NUM_CH-1:0]                     ch_valid_i,
  output logic [NUM_CH-1:0]                     ch_ready_o,
  input  logic [NUM_CH-1:0]                     ch_en_i,
  output logic [NUM_CH*calc_mw(FIFO_DEPTH)-1:0] ch_margin_o,
  output logic [DATA_W-1:0]                     mcdt_data_o,
  output logic                                  mcdt_val_o,
  output logic [calc_idw(NUM_CH)-1:0]           mcdt_id_o,
  input  logic                                  mcdt_ready_i
);

  localparam int MW  = calc_mw(FIFO_DEPTH);
  localparam int IDW = calc_idw(NUM_CH);
  localparam logic [MW-1:0]  FULL    = MW'(FIFO_DEPTH);
  localparam logic [IDW-1:0] LAST_CH = IDW'(NUM_CH - 1);

  logic [MW-1:0]     count [NUM_CH];
  logic [DATA_W-1:0] fifo_dout [NUM_CH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] cand;
  logic              out_free;
  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic [DATA_W-1:0] sel_data;
  logic [IDW-1:0]    last_grant_reg;
  logic [DATA_W-1:0] data_reg;
  logic              val_reg;
  logic [IDW-1:0]    id_reg;

  assign out_free = !val_reg || mcdt_ready_i;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_ready_o[gi] = ch_en_i[gi] && (count[gi] != FULL);
      assign push[gi]       = ch_valid_i[gi] && ch_ready_o[gi];
      assign cand[gi]       = ch_en_i[gi] && (count[gi] != '0);
      assign pop[gi]        = out_free && grant_found && (grant_idx == IDW'(gi));

      chnl_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk    (clk_i),
        .rstn   (rstn_i),
        .push   (push[gi]),
        .pop    (pop[gi]),
        .din    (ch_data_i[gi*DATA_W +: DATA_W]),
        .dout   (fifo_dout[gi]),
        .count  (count[gi]),
        .margin (ch_margin_o[gi*MW +: MW])
      );
    end
  endgenerate

  // Two passes: indices at/after the start point, then the wrapped-around ones.
  // Fixed priority is the degenerate case start = 0.
  always_comb begin
    int start;
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_data    = '0;
    start       = (ARB_MODE == int'(ARB_RR)) ? int'(last_grant_reg) + 1 : 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_found && cand[k] && (k >= start)) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(k);
        sel_data    = fifo_dout[k];
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_found && cand[k] && (k < start)) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(k);
        sel_data    = fifo_dout[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      data_reg       <= '0;
      val_reg        <= 1'b0;
      id_reg         <= '0;
      last_grant_reg <= LAST_CH;
    end else if (out_free) begin
      if (grant_found) begin
        data_reg       <= sel_data;
        id_reg         <= grant_idx;
        val_reg        <= 1'b1;
        last_grant_reg <= grant_idx;
      end else begin
        val_reg <= 1'b0;
      end
    end
  end

  assign mcdt_data_o = data_reg;
  assign mcdt_val_o  = val_reg;
  assign mcdt_id_o   = id_reg;

endmodule

// File: tb/tb_mcdt_multi.sv
// Bench for mcdt_multi: a fixed-priority and a round-robin instance share all
// inputs and are each checked every cycle against a queue-based model.
module tb_mcdt_multi;
  localparam int NCH = 3;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int MW = 6;
  localparam int IDW = 2;
  localparam logic [NCH*MW-1:0] RST_MARGIN = {3{6'd32}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0] ch_valid;
  logic [NCH-1:0] ch_en;
  logic mready;

  logic [NCH-1:0] ready_d [2];
  logic [NCH*MW-1:0] margin_d [2];
  logic [DW-1:0] data_d [2];
  logic val_d [2];
  logic [IDW-1:0] id_d [2];

  mcdt_multi #(.NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(0)) u_fixed (
    .clk_i(clk), .rstn_i(rstn), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
    .ch_ready_o(ready_d[0]), .ch_en_i(ch_en), .ch_margin_o(margin_d[0]),
    .mcdt_data_o(data_d[0]), .mcdt_val_o(val_d[0]), .mcdt_id_o(id_d[0]),
    .mcdt_ready_i(mready));

  mcdt_multi #(.NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(1)) u_rr (
    .clk_i(clk), .rstn_i(rstn), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
    .ch_ready_o(ready_d[1]), .ch_en_i(ch_en), .ch_margin_o(margin_d[1]),
    .mcdt_data_o(data_d[1]), .mcdt_val_o(val_d[1]), .mcdt_id_o(id_d[1]),
    .mcdt_ready_i(mready));

  int tests = 0;
  int failed = 0;
  bit check_on = 1'b0;

  // Model state per instance d: channel queues at index d*NCH+k, output stage, last grant.
  logic [DW-1:0] mq [2*NCH][$];
  logic exp_val [2];
  logic [DW-1:0] exp_data [2];
  int exp_id [2];
  int last_g [2];
  int log_id [2][$];
  logic [DW-1:0] log_data [2][$];

  int fixed_ids [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  int rr_ids [12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};

  task automatic check(input string name, input int d, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [NCH-1:0] acc;
    int g;
    int k;
    for (int d = 0; d < 2; d++) begin
      if (rstn && val_d[d] && mready) begin
        log_id[d].push_back(int'(id_d[d]));
        log_data[d].push_back(data_d[d]);
      end
      if (!rstn) begin
        for (int c = 0; c < NCH; c++) mq[d*NCH+c].delete();
        exp_val[d] = 1'b0;
        exp_data[d] = '0;
        exp_id[d] = 0;
        last_g[d] = NCH - 1;
      end else begin
        for (int c = 0; c < NCH; c++)
          acc[c] = ch_valid[c] && ch_en[c] && (mq[d*NCH+c].size() < DEPTH);
        if (!exp_val[d] || mready) begin
          g = -1;
          for (int i = 0; i < NCH; i++) begin
            k = (d == 1) ? (last_g[d] + 1 + i) % NCH : i;
            if (g < 0 && ch_en[k] && mq[d*NCH+k].size() > 0) g = k;
          end
          if (g >= 0) begin
            exp_data[d] = mq[d*NCH+g].pop_front();
            exp_id[d] = g;
            exp_val[d] = 1'b1;
            last_g[d] = g;
          end else begin
            exp_val[d] = 1'b0;
          end
        end
        for (int c = 0; c < NCH; c++)
          if (acc[c]) mq[d*NCH+c].push_back(ch_data[c*DW +: DW]);
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      for (int d = 0; d < 2; d++) begin
        check("val", d, val_d[d], exp_val[d]);
        check("data", d, data_d[d], exp_data[d]);
        check("id", d, id_d[d], exp_id[d]);
        for (int k = 0; k < NCH; k++) begin
          check("ready", d, ready_d[d][k], ch_en[k] && (mq[d*NCH+k].size() < DEPTH));
          check("margin", d, margin_d[d][k*MW +: MW], DEPTH - mq[d*NCH+k].size());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    ch_data[k*DW +: DW] = v;
  endtask

  task automatic rand_data();
    for (int k = 0; k < NCH; k++) set_data(k, $urandom);
  endtask

  function automatic bit model_idle();
    for (int d = 0; d < 2; d++) begin
      if (exp_val[d]) return 1'b0;
      for (int k = 0; k < NCH; k++)
        if (ch_en[k] && mq[d*NCH+k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain();
    bit idle;
    ch_valid = '0;
    mready = 1'b1;
    idle = 1'b0;
    for (int c = 0; c < 800 && !idle; c++) begin
      tick();
      idle = model_idle();
    end
    check("drain_done", 0, idle, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int b1;
    int n2;
    rstn = 1'b0;
    ch_en = '1;
    ch_valid = '0;
    mready = 1'b0;
    ch_data = '0;
    repeat (3) tick();
    check_on = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check("reset_val", d, val_d[d], 0);
      check("reset_margin", d, margin_d[d], RST_MARGIN);
      check("reset_ready", d, ready_d[d], 3'b111);
    end
    rstn = 1'b1;
    mready = 1'b1;
    tick();

    // Basic: ten words on channel 1 with an idle cycle between writes.
    b0 = log_id[0].size();
    for (int i = 0; i < 10; i++) begin
      ch_valid = 3'b010;
      set_data(1, 32'h00C1_0000 + i);
      tick();
      ch_valid = '0;
      tick();
    end
    drain();
    check("basic_count", 0, log_id[0].size() - b0, 10);
    for (int i = 0; i < 10; i++) begin
      check("basic_id", 0, log_id[0][b0+i], 1);
      check("basic_data", 0, log_data[0][b0+i], 32'h00C1_0000 + i);
    end
    check("basic_margin", 0, margin_d[0][MW +: MW], 32);

    // Fill: channel 0 bursts 40 words against a stalled output.
    b0 = log_id[0].size();
    mready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ch_valid = 3'b001;
      set_data(0, 32'h00F0_0000 + i);
      tick();
    end
    ch_valid = '0;
    for (int d = 0; d < 2; d++) begin
      check("fill_ready", d, ready_d[d][0], 0);
      check("fill_margin", d, margin_d[d][0 +: MW], 0);
    end
    mready = 1'b1;
    tick();
    mready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("pop_ready", d, ready_d[d][0], 1);
      check("pop_margin", d, margin_d[d][0 +: MW], 1);
    end
    drain();
    check("fill_count", 0, log_id[0].size() - b0, 33);
    check("fill_last", 0, log_data[0][b0+32], 32'h00F0_0020);

    // Arbitration order from a fresh reset with four words per channel.
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    b0 = log_id[0].size();
    b1 = log_id[1].size();
    mready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_valid = 3'b111;
      for (int k = 0; k < NCH; k++) set_data(k, 32'h00A0_0000 + k * 16 + i);
      tick();
    end
    ch_valid = '0;
    tick();
    drain();
    check("arb_fixed_count", 0, log_id[0].size() - b0, 12);
    check("arb_rr_count", 1, log_id[1].size() - b1, 12);
    for (int j = 0; j < 12; j++) begin
      check("arb_fixed_id", 0, log_id[0][b0+j], fixed_ids[j]);
      check("arb_rr_id", 1, log_id[1][b1+j], rr_ids[j]);
    end

    // Backpressure: ready pattern 1,0,0,1 under random traffic.
    for (int c = 0; c < 200; c++) begin
      ch_valid = NCH'($urandom);
      rand_data();
      mready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    drain();

    // Enable: park five words on channel 2 while it is disabled.
    mready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ch_valid = 3'b100;
      set_data(2, 32'h00C2_0000 + i);
      tick();
    end
    ch_valid = '0;
    ch_en = 3'b011;
    tick();
    for (int d = 0; d < 2; d++) begin
      check("dis_ready", d, ready_d[d][2], 0);
      check("dis_margin", d, margin_d[d][2*MW +: MW], 27);
    end
    b0 = log_id[0].size();
    mready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      ch_valid = NCH'($urandom) & 3'b011;
      rand_data();
      tick();
    end
    drain();
    n2 = 0;
    for (int j = b0; j < log_id[0].size(); j++) if (log_id[0][j] == 2) n2++;
    check("dis_id2_count", 0, n2, 1);
    check("dis_margin_hold", 0, margin_d[0][2*MW +: MW], 27);
    ch_en = 3'b111;
    b0 = log_id[0].size();
    drain();
    check("reen_count", 0, log_id[0].size() - b0, 5);
    for (int j = 0; j < 5; j++) begin
      check("reen_id", 0, log_id[0][b0+j], 2);
      check("reen_data", 0, log_data[0][b0+j], 32'h00C2_0001 + j);
    end

    // Reset in the middle of a burst with writes still presented.
    mready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ch_valid = NCH'($urandom);
      rand_data();
      tick();
    end
    rstn = 1'b0;
    ch_valid = 3'b111;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_mid_val", d, val_d[d], 0);
      check("rst_mid_margin", d, margin_d[d], RST_MARGIN);
    end
    rstn = 1'b1;
    ch_valid = '0;
    mready = 1'b1;
    b0 = log_id[0].size();
    tick();
    tick();
    check("rst_no_stale", 0, log_id[0].size() - b0, 0);

    // Random enables, writes and downstream readiness.
    for (int c = 0; c < 400; c++) begin
      ch_en = NCH'($urandom);
      ch_valid = NCH'($urandom);
      rand_data();
      mready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ch_en = 3'b111;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
